// File: rtl/serial_borrow_subtractor_pkg.sv
// Shared definitions for the serial borrow subtractor: FSM states and
// elaboration-time helpers for parameter checking and counter sizing.
package serial_borrow_subtractor_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Digit counter width: max(1, clog2(WIDTH/DIGIT)).
  function automatic int unsigned cnt_width(int unsigned width, int unsigned digit);
    int unsigned n;
    n = width / digit;
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_ok(int unsigned width, int unsigned digit);
    return (digit != 0) && (width >= 2) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/digit_borrow_subtractor.sv
// Combinational DIGIT-bit ripple of full subtractors: d = a - b - bin.
module digit_borrow_subtractor #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  always_comb begin : p_ripple
    logic br;
    br = bin;
    d  = '0;
    for (int i = 0; i < DIGIT; i++) begin
      d[i] = a[i] ^ b[i] ^ br;
      br   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
    end
    bout = br;
  end

endmodule

// File: rtl/serial_borrow_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, DIGIT bits per clock, LSB digit first,
// with start/busy/done framing and unsigned borrow / signed overflow flags.
module serial_borrow_subtractor
  import serial_borrow_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = cnt_width(WIDTH, DIGIT);

  if (!params_ok(WIDTH, DIGIT)) begin : gen_param_err
    $error("serial_borrow_subtractor: DIGIT must divide WIDTH and WIDTH must be >= 2");
  end

  state_e          state_q;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q, a_msb_q, b_msb_q;
  logic             busy_q, done_q, bout_q, ovf_q;

  logic [DIGIT-1:0] digit_d;
  logic             digit_bout;
  logic [WIDTH-1:0] diff_shift;
  logic             last_digit;

  digit_borrow_subtractor #(
    .DIGIT(DIGIT)
  ) u_digit (
    .a   (a_q[DIGIT-1:0]),
    .b   (b_q[DIGIT-1:0]),
    .bin (borrow_q),
    .d   (digit_d),
    .bout(digit_bout)
  );

  // New digit enters diff from the top so the LSB digit ends up at the bottom.
  always_comb begin
    diff_shift = (diff_q >> DIGIT) | ((WIDTH)'(digit_d) << (WIDTH - DIGIT));
    last_digit = (cnt_q == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (start) begin
            state_q  <= StRun;
            busy_q   <= 1'b1;
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;
            a_msb_q  <= a[WIDTH-1];
            b_msb_q  <= b[WIDTH-1];
            cnt_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StRun: begin
          diff_q   <= diff_shift;
          borrow_q <= digit_bout;
          a_q      <= a_q >> DIGIT;
          b_q      <= b_q >> DIGIT;
          cnt_q    <= cnt_q + 1'b1;
          if (last_digit) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            bout_q  <= digit_bout;
            ovf_q   <= (a_msb_q != b_msb_q) && (diff_shift[WIDTH-1] != a_msb_q);
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/serial_borrow_subtractor.md
# serial_borrow_subtractor

Parametrised multi-cycle subtractor computing diff = a − b − bin over WIDTH-bit operands, DIGIT bits per clock, using a registered borrow chain instead of a full-width combinational ripple. It sits beside the combinational ripple borrow subtractor in the arithmetic library. Designs use it where area or timing outweighs latency. A start/busy/done handshake frames each operation. Unsigned borrow-out and signed overflow flags are produced.

## Interface
- WIDTH, 8, operand/result width in bits; ≥ 2
- DIGIT, 1, bits processed per cycle; must divide WIDTH (elaboration error otherwise)
- clk  input  1  sole clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when state is IDLE or DONE
- a  input  WIDTH  minuend, captured on accepted start
- b  input  WIDTH  subtrahend, captured on accepted start
- bin  input  1  borrow-in, captured on accepted start
- busy  output  1  high while state is RUN
- done  output  1  one-cycle pulse, result valid
- diff  output  WIDTH  a − b − bin mod 2^WIDTH, held until next accepted start
- bout  output  1  final borrow (1 ⇔ a < b + bin, unsigned)
- ovf  output  1  signed two's-complement overflow of a − b − bin

## Operation
- N = WIDTH/DIGIT digits, processed LSB digit first.
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on start. Load the a/b shift registers and the borrow register (= bin). Latch a[WIDTH-1] and b[WIDTH-1]. Clear digit counter and diff.
- RUN: each edge subtracts the low DIGIT bits of a/b with the borrow register.
  - Shift the resulting DIGIT bits into diff from the top.
  - Update the borrow register with the digit borrow-out.
  - Shift a/b right by DIGIT and increment the counter.
- RUN → DONE on the edge that processes digit N−1.
- DONE: done=1; diff final; bout = borrow register; ovf = (a_msb≠b_msb) & (diff[WIDTH-1]≠a_msb).
- DONE → RUN if start is high (back-to-back operation, new operands captured). DONE → IDLE otherwise.
- start during RUN is ignored: no capture, no queueing, operation unaffected.
- Operands changing after capture have no effect.
- bout/ovf are valid from DONE onward and held in IDLE until the next accepted start.
- bout/ovf are undefined-free: they read 0 after reset and are cleared on an accepted start.

## Timing
- Reset (rst high at an edge, any state): state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0, counter=0.
- rst wins over start at the same edge.
- Reset mid-RUN aborts the operation; no done is produced.
- start sampled high at edge E0 → busy high from E0 through E0+N−1 → done high for exactly the cycle after edge E0+N.
- Latency = N cycles start-edge to done, i.e. WIDTH=8: 8 cycles at DIGIT=1, 2 cycles at DIGIT=4, 1 cycle at DIGIT=WIDTH.
- Throughput: one operation per N+1 cycles; start held high continuously gives that rate.
- busy and done are never high together.
- Outputs are registered. No combinational path from inputs to outputs.
- Counter width = max(1, clog2(N)). Its wrap at N is unreachable because the FSM leaves RUN first.

## Structure
- Shared arithmetic package contains:
  - FSM state enum {IDLE, RUN, DONE}
  - function computing counter width from WIDTH/DIGIT
  - parameter-check macro/assertion for WIDTH % DIGIT == 0
- Sub-module digit_borrow_subtractor: combinational DIGIT-bit ripple of full subtractors.
  - Ports: a, b, bin, d, bout.
  - Parametrised by DIGIT; instantiated once.
- Top holds the FSM, counter, operand shift registers, borrow register, sign latches and result register.

## Test plan
- Basic subtract, WIDTH=8, DIGIT=1: a=0x35, b=0x12, bin=0, start pulse → done exactly 8 cycles later; diff=0x23, bout=0, ovf=0.
- Borrow cases: a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1, ovf=0. a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1.
- Signed overflow: a=0x80, b=0x01 → diff=0x7F, bout=0, ovf=1. a=0x7F, b=0xFF → diff=0x80, bout=1, ovf=1.
- Width/digit sweep: DIGIT ∈ {1, 2, 4, 8}, WIDTH=8.
  - Exhaustive a, b ∈ 0..255, bin ∈ {0, 1}, checked against the reference model a−b−bin.
  - done latency must be 8, 4, 2, 1 respectively.
- Handshake: start re-pulsed at cycle 3 of RUN with different operands → ignored, original result returned. start held high → results every 9 cycles (DIGIT=1), busy/done never overlapping.
- Reset mid-operation: rst asserted during RUN cycle 4 → next cycle busy=0, diff=0, bout=0, ovf=0; no done pulse. A following start completes normally.
